// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, step modes.
package mdu_pkg;

  localparam int ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Combinational, zero latency; no flow control.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mode_t              mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_nxt = acc;
    if (mode == MODE_DIV) begin
      // acc = {remainder, dividend bits still to shift in / quotient bits shifted out}
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, operand};
      if (diff[WIDTH]) begin
        acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      // acc = {partial product high, multiplier bits not yet consumed}
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit; start at edge E0 -> HI/LO valid and done after E33.
// No backpressure: start/mthi/mtlo are ignored while busy, decode stalls on busy.
module mult_div_unit
  import mdu_pkg::state_t, mdu_pkg::IDLE, mdu_pkg::CALC, mdu_pkg::FIX,
         mdu_pkg::mode_t, mdu_pkg::MODE_MUL, mdu_pkg::MODE_DIV,
         mdu_pkg::OP_MULT, mdu_pkg::OP_DIV, mdu_pkg::OP_DIVU;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = mdu_pkg::ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_acc;
  logic [WIDTH-1:0]   operand;
  mode_t              mode;
  logic               sign_q;
  logic               sign_r;

  logic               is_signed;
  logic               is_div;
  logic               opb_zero;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod_neg;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign opb_zero  = (opb == '0);
  // Negating 0x80000000 wraps to itself, which is the correct unsigned magnitude.
  assign abs_a     = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b     = (is_signed && opb[WIDTH-1]) ? -opb : opb;

  assign quo       = acc[WIDTH-1:0];
  assign rem       = acc[2*WIDTH-1:WIDTH];
  assign prod_neg  = -acc;

  assign busy      = (state != IDLE);

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode    (mode),
    .acc     (acc),
    .operand (operand),
    .acc_nxt (step_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      operand <= '0;
      mode    <= MODE_MUL;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= {{WIDTH{1'b0}}, abs_a};
            operand <= abs_b;
            mode    <= is_div ? MODE_DIV : MODE_MUL;
            cnt     <= '0;
            // Divide by zero must leave LO all ones, so the quotient is never negated then.
            sign_q  <= is_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]) && !(is_div && opb_zero);
            sign_r  <= is_signed && opa[WIDTH-1];
          end else begin
            if (mthi) hi_out <= opa;
            if (mtlo) lo_out <= opa;
          end
        end
        CALC: begin
          acc <= step_acc;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (mode == MODE_DIV) begin
            lo_out <= sign_q ? -quo : quo;
            hi_out <= sign_r ? -rem : rem;
          end else begin
            {hi_out, lo_out} <= sign_q ? prod_neg : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO results and latency checks.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .opa    (opa),
    .opb    (opb),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .busy   (busy),
    .done   (done)
  );

  // Issue one op and wait (bounded) for done; lat = edges after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({busy, done, hi_out, lo_out} !== 66'b0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi_out, lo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu();
    int lat;
    bit bok;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bok);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL multu_latency: got %0d want 33", lat); end
    total++;
    if (bok !== 1'b1) begin bad++; $display("FAIL multu_busy_held: got %b want 1", bok); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL multu_busy_at_done: got %b want 0", busy); end
    total++;
    if (hi_out !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want fffffffe", hi_out); end
    total++;
    if (lo_out !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want 00000001", lo_out); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_signed();
    int lat;
    bit bok;
    do_op(2'b00, 32'hFFFFFFFE, 32'h00000003, lat, bok);
    total++;
    if (hi_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi_out); end
    total++;
    if (lo_out !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_neg_lo: got %h want fffffffa", lo_out); end
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, lat, bok);
    total++;
    if (lo_out !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", lo_out); end
    total++;
    if (hi_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", hi_out); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", lat); end
  endtask

  task automatic test_div_corner();
    int lat;
    bit bok;
    do_op(2'b11, 32'h12345678, 32'h00000000, lat, bok);
    total++;
    if (lo_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo: got %h want ffffffff", lo_out); end
    total++;
    if (hi_out !== 32'h12345678) begin bad++; $display("FAIL divu_zero_hi: got %h want 12345678", hi_out); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL divu_zero_latency: got %0d want 33", lat); end
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000000, lat, bok);
    total++;
    if (lo_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_zero_lo: got %h want ffffffff", lo_out); end
    total++;
    if (hi_out !== 32'hFFFFFFF9) begin bad++; $display("FAIL div_zero_hi: got %h want fffffff9", hi_out); end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bok);
    total++;
    if (lo_out !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo: got %h want 80000000", lo_out); end
    total++;
    if (hi_out !== 32'h00000000) begin bad++; $display("FAIL div_ovf_hi: got %h want 00000000", hi_out); end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    int done_at;
    ndone = 0;
    done_at = -1;
    @(negedge clk);
    start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (done === 1'b1) begin ndone++; done_at = c; end
      if (c == 5) begin start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd5; end
      if (c == 6) start = 1'b0;
      if (c == 8) begin mthi = 1'b1; opa = 32'hDEADBEEF; end
      if (c == 9) mthi = 1'b0;
      @(negedge clk);
    end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL busy_single_done: got %0d want 1", ndone); end
    total++;
    if (done_at !== 33) begin bad++; $display("FAIL busy_done_cycle: got %0d want 33", done_at); end
    total++;
    if (lo_out !== 32'd14) begin bad++; $display("FAIL busy_lo: got %h want 0000000e", lo_out); end
    total++;
    if (hi_out !== 32'd2) begin bad++; $display("FAIL busy_hi: got %h want 00000002", hi_out); end
  endtask

  task automatic test_moves();
    int n;
    @(negedge clk);
    mthi = 1'b1; opa = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    total++;
    if (hi_out !== 32'hA5A5A5A5) begin bad++; $display("FAIL mthi_hi: got %h want a5a5a5a5", hi_out); end
    total++;
    if (lo_out !== 32'd14) begin bad++; $display("FAIL mthi_lo_kept: got %h want 0000000e", lo_out); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL mthi_done: got %b want 0", done); end
    mtlo = 1'b1; opa = 32'h5A5A5A5A;
    @(negedge clk);
    mtlo = 1'b0;
    total++;
    if (lo_out !== 32'h5A5A5A5A) begin bad++; $display("FAIL mtlo_lo: got %h want 5a5a5a5a", lo_out); end
    total++;
    if (hi_out !== 32'hA5A5A5A5) begin bad++; $display("FAIL mtlo_hi_kept: got %h want a5a5a5a5", hi_out); end
    mthi = 1'b1; mtlo = 1'b1; opa = 32'h11111111;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    total++;
    if ({hi_out, lo_out} !== 64'h11111111_11111111) begin
      bad++; $display("FAIL mthilo_both: got %h_%h want 11111111_11111111", hi_out, lo_out);
    end
    start = 1'b1; mthi = 1'b1; op = 2'b01; opa = 32'd6; opb = 32'd7;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    total++;
    if (hi_out !== 32'h11111111) begin bad++; $display("FAIL start_mthi_dropped: got %h want 11111111", hi_out); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL start_mthi_busy: got %b want 1", busy); end
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    total++;
    if ({hi_out, lo_out} !== 64'd42) begin
      bad++; $display("FAIL start_mthi_result: got %h_%h want 00000000_0000002a", hi_out, lo_out);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit bok;
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'hFFFFFFFE; opb = 32'h00000003;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, hi_out, lo_out} !== 66'b0) begin
      bad++;
      $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi_out, lo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'b01, 32'd3, 32'd4, lat, bok);
    total++;
    if (lo_out !== 32'd12) begin bad++; $display("FAIL post_reset_lo: got %h want 0000000c", lo_out); end
    total++;
    if (hi_out !== 32'd0) begin bad++; $display("FAIL post_reset_hi: got %h want 00000000", hi_out); end
    total++;
    if (lat !== 33) begin bad++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_corner();
    test_busy_ignore();
    test_moves();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
